// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with busy-bit scoreboard.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    function automatic int calc_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: array mux, hard-wired zero register and optional write bypass.
module regfile_rdport
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int AW     = calc_aw(NREGS),
    parameter int BYPASS = 1
) (
    input  logic [XLEN-1:0]  regs [NREGS],
    input  logic [NREGS-1:0] busy,
    input  logic [AW-1:0]    raddr,
    input  logic [AW-1:0]    waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic             wen,
    input  logic [AW-1:0]    resv_addr,
    input  logic             resv_en,
    output logic [XLEN-1:0]  rdata,
    output logic             rbusy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    always_comb begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
        // A forwarded write retires the reservation unless it is re-reserved this cycle.
        if (BYPASS != 0 && wen && waddr == raddr) begin
            rdata = wdata;
            rbusy = resv_en && (resv_addr == waddr);
        end
        if (raddr == ZERO_ADDR) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits and a pending-write counter
// for in-order issue / out-of-order writeback tracking.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                wen,
    input  logic [AW-1:0]       resv_addr,
    input  logic                resv_en,
    input  logic                flush,
    output logic [AW:0]         pending
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      pending_d;
    logic             wr_ok;
    logic             rv_ok;
    logic             inc;
    logic             dec;

    assign wr_ok = wen && (waddr != ZERO_ADDR);
    assign rv_ok = resv_en && (resv_addr != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Reserve is applied after the write-clear so it wins on a shared target.
    always_comb begin
        busy_d = busy;
        if (wr_ok) begin
            busy_d[waddr] = 1'b0;
        end
        if (rv_ok) begin
            busy_d[resv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Counter deltas mirror exactly the bit transitions made in busy_d.
    always_comb begin
        inc = rv_ok && !busy[resv_addr];
        dec = wr_ok && busy[waddr] && !(rv_ok && resv_addr == waddr);
        if (flush) begin
            pending_d = '0;
        end else begin
            pending_d = pending + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            pending <= '0;
        end else begin
            busy    <= busy_d;
            pending <= pending_d;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rdport
        regfile_rdport #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .regs      (regs),
            .busy      (busy),
            .raddr     (raddr[p*AW +: AW]),
            .waddr     (waddr),
            .wdata     (wdata),
            .wen       (wen),
            .resv_addr (resv_addr),
            .resv_en   (resv_en),
            .rdata     (rdata[p*XLEN +: XLEN]),
            .rbusy     (rbusy[p])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (XLEN=32, NREGS=32, NRP=2, BYPASS=1).
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic [NRP*AW-1:0]   raddr;
    logic [NRP*XLEN-1:0] rdata;
    logic [NRP-1:0]      rbusy;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                wen;
    logic [AW-1:0]       resv_addr;
    logic                resv_en;
    logic                flush;
    logic [AW:0]         pending;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_scoreboard #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NRP    (NRP),
        .BYPASS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .resv_addr (resv_addr),
        .resv_en   (resv_en),
        .flush     (flush),
        .pending   (pending)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge, then leave the inputs 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; resv_en = 1'b0; flush = 1'b0;
        waddr = '0; wdata = '0; resv_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic reserve(input int a);
        idle();
        resv_addr = AW'(a);
        resv_en   = 1'b1;
        step();
        idle();
    endtask

    task automatic check_port(input string tag, input int a, input logic [31:0] exp_d,
                              input logic exp_b);
        set_rd(a, a);
        check({tag, "_rdata0"}, rdata[0 +: XLEN], exp_d);
        check({tag, "_rdata1"}, rdata[XLEN +: XLEN], exp_d);
        check({tag, "_rbusy0"}, 32'(rbusy[0]), 32'(exp_b));
        check({tag, "_rbusy1"}, 32'(rbusy[1]), 32'(exp_b));
    endtask

    initial begin
        idle();
        raddr = '0;
        rst   = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state: all addresses, ports read opposite ends
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            check("rst_rdata0", rdata[0 +: XLEN], 32'h0);
            check("rst_rdata1", rdata[XLEN +: XLEN], 32'h0);
            check("rst_rbusy", 32'(rbusy), 32'h0);
        end
        check("rst_pending", 32'(pending), 32'd0);

        // reserve x5, then write it with same-cycle bypass
        reserve(5);
        check("r5_pending", 32'(pending), 32'd1);
        check_port("r5_busy", 5, 32'h0, 1'b1);
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        check_port("w5_bypass", 5, 32'hDEADBEEF, 1'b0);
        check("w5_pending_pre", 32'(pending), 32'd1);
        step();
        idle();
        check_port("w5_after", 5, 32'hDEADBEEF, 1'b0);
        check("w5_pending", 32'(pending), 32'd0);

        // reserve and write x7 together: reserve wins
        resv_en = 1'b1; resv_addr = 5'd7;
        wen = 1'b1; waddr = 5'd7; wdata = 32'h12;
        check_port("rw7_bypass", 7, 32'h12, 1'b1);
        step();
        idle();
        check_port("rw7_after", 7, 32'h12, 1'b1);
        check("rw7_pending", 32'(pending), 32'd1);

        // register 0 ignores writes and reservations
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        resv_en = 1'b1; resv_addr = 5'd0;
        check_port("x0_same", 0, 32'h0, 1'b0);
        step();
        idle();
        check_port("x0_after", 0, 32'h0, 1'b0);
        check("x0_pending", 32'(pending), 32'd1);

        // retire x7, write a non-busy register, double-reserve x10
        wen = 1'b1; waddr = 5'd7; wdata = 32'h34;
        step();
        idle();
        check("w7_pending", 32'(pending), 32'd0);
        wen = 1'b1; waddr = 5'd9; wdata = 32'h55;
        step();
        idle();
        check_port("w9_nobusy", 9, 32'h55, 1'b0);
        check("w9_pending", 32'(pending), 32'd0);
        reserve(10);
        reserve(10);
        check("r10x2_pending", 32'(pending), 32'd1);
        check_port("r10x2_busy", 10, 32'h0, 1'b1);

        // flush overrides a same-cycle reserve; same-cycle write still lands
        reserve(1);
        reserve(2);
        reserve(3);
        check("pre_flush_pending", 32'(pending), 32'd4);
        flush = 1'b1; resv_en = 1'b1; resv_addr = 5'd4;
        wen = 1'b1; waddr = 5'd11; wdata = 32'hABCD;
        step();
        idle();
        check("flush_pending", 32'(pending), 32'd0);
        for (int a = 1; a <= 4; a++) begin
            check_port("flush_clear", a, 32'h0, 1'b0);
        end
        check_port("flush_x10", 10, 32'h0, 1'b0);
        check_port("flush_x5", 5, 32'hDEADBEEF, 1'b0);
        check_port("flush_x11", 11, 32'hABCD, 1'b0);

        // reserve and retire distinct registers in one cycle: net zero
        reserve(12);
        resv_en = 1'b1; resv_addr = 5'd13;
        wen = 1'b1; waddr = 5'd12; wdata = 32'h77;
        step();
        idle();
        check("net0_pending", 32'(pending), 32'd1);
        check_port("net0_x12", 12, 32'h77, 1'b0);
        check_port("net0_x13", 13, 32'h0, 1'b1);

        // fill every reservable register, then reset with competing activity
        for (int a = 1; a < NREGS; a++) begin
            reserve(a);
        end
        check("full_pending", 32'(pending), 32'd31);
        check_port("full_x31", 31, 32'h0, 1'b1);
        rst = 1'b1;
        wen = 1'b1; waddr = 5'd6; wdata = 32'h99;
        resv_en = 1'b1; resv_addr = 5'd8; flush = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("rst2_pending", 32'(pending), 32'd0);
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            check("rst2_rdata0", rdata[0 +: XLEN], 32'h0);
            check("rst2_rdata1", rdata[XLEN +: XLEN], 32'h0);
            check("rst2_rbusy", 32'(rbusy), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
